vc_demux_buf: RTL and testbench

VC_DEMUX_BUF -- requirements
Module: vc_demux_buf

---
 rtl/vc_demux_buf.sv | 100 ++++++++++
 tb/tb_vc_demux_buf.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vc_demux_buf.sv
// Two-VC link demultiplexer: each incoming flit lands in a per-VC first-word
// fall-through buffer; every freed slot is returned upstream as a one-cycle credit pulse.
module vc_demux_buf #(
  parameter int DATA_W = 36,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              ivalid,
  input  logic [DATA_W-1:0] idata,
  input  logic              ivch,
  output logic              ovalid0,
  output logic              ovalid1,
  output logic [DATA_W-1:0] odata0,
  output logic [DATA_W-1:0] odata1,
  input  logic              iready0,
  input  logic              iready1,
  output logic [1:0]        credit,
  output logic [CNT_W-1:0]  count0,
  output logic [CNT_W-1:0]  count1,
  output logic [1:0]        ovf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Handshake: VC k transfers its head flit on a rising edge exactly when
  // ovalid_k and iready_k are both 1; iready_k alone does nothing, and
  // ovalid_k never depends on iready_k.
  logic [DATA_W-1:0] mem_q    [2][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [2];
  logic [PTR_W-1:0]  rd_ptr_q [2];
  logic [CNT_W-1:0]  cnt_q    [2];
  logic [1:0]        credit_q;
  logic [1:0]        ovf_q;

  logic [1:0] iready;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] accept;
  logic [1:0] drop;

  assign iready = {iready1, iready0};

  // A push into a full VC survives only if the same edge frees the head slot.
  always_comb begin
    push   = '0;
    pop    = '0;
    accept = '0;
    drop   = '0;
    for (int k = 0; k < 2; k++) begin
      push[k]   = ivalid && (ivch == k[0]);
      pop[k]    = (cnt_q[k] != '0) && iready[k];
      accept[k] = push[k] && ((cnt_q[k] != FULL_CNT) || pop[k]);
      drop[k]   = push[k] && (cnt_q[k] == FULL_CNT) && !pop[k];
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      for (int k = 0; k < 2; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
      end
      credit_q <= '0;
      ovf_q    <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (accept[k]) wr_ptr_q[k] <= wr_ptr_q[k] + PTR_W'(1);
        if (pop[k])    rd_ptr_q[k] <= rd_ptr_q[k] + PTR_W'(1);
        case ({accept[k], pop[k]})
          2'b10:   cnt_q[k] <= cnt_q[k] + CNT_W'(1);
          2'b01:   cnt_q[k] <= cnt_q[k] - CNT_W'(1);
          default: cnt_q[k] <= cnt_q[k];
        endcase
        credit_q[k] <= pop[k];
        if (drop[k]) ovf_q[k] <= 1'b1;
      end
    end
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (accept[k] && !rst_) mem_q[k][wr_ptr_q[k]] <= idata;
    end
  end

  assign ovalid0 = (cnt_q[0] != '0);
  assign ovalid1 = (cnt_q[1] != '0);
  assign odata0  = mem_q[0][rd_ptr_q[0]];
  assign odata1  = mem_q[1][rd_ptr_q[1]];
  assign count0  = cnt_q[0];
  assign count1  = cnt_q[1];
  assign credit  = credit_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_vc_demux_buf.sv
// Directed bench for vc_demux_buf: hand-computed vectors checked with immediate
// assertions; drain order is compared against an expected queue.
module tb_vc_demux_buf;

  localparam int DATA_W = 36;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst_;
  logic              ivalid;
  logic [DATA_W-1:0] idata;
  logic              ivch;
  logic              ovalid0, ovalid1;
  logic [DATA_W-1:0] odata0, odata1;
  logic              iready0, iready1;
  logic [1:0]        credit;
  logic [CNT_W-1:0]  count0, count1;
  logic [1:0]        ovf;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] d;

  vc_demux_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_    (rst_),
    .ivalid  (ivalid),
    .idata   (idata),
    .ivch    (ivch),
    .ovalid0 (ovalid0),
    .ovalid1 (ovalid1),
    .odata0  (odata0),
    .odata1  (odata1),
    .iready0 (iready0),
    .iready1 (iready1),
    .credit  (credit),
    .count0  (count0),
    .count1  (count1),
    .ovf     (ovf)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // drivers
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic ch, input logic [DATA_W-1:0] dat,
                        input logic r0, input logic r1);
    ivalid  = v;
    ivch    = ch;
    idata   = dat;
    iready0 = r0;
    iready1 = r1;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_ = 1'b1;
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_ovalid0", ovalid0, 0);
    chk("reset_ovalid1", ovalid1, 0);
    chk("reset_count0", count0, 0);
    chk("reset_count1", count1, 0);
    chk("reset_credit", credit, 0);
    chk("reset_ovf", ovf, 0);
    rst_ = 1'b0;

    // single push on VC0, visible the next cycle
    set_in(1'b1, 1'b0, 36'h0_0000_00A1, 1'b0, 1'b0);
    cycle();
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("a1_ovalid0", ovalid0, 1);
    chk("a1_odata0", odata0, 36'h0_0000_00A1);
    chk("a1_count0", count0, 1);
    chk("a1_ovalid1", ovalid1, 0);
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle();
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("a1_pop_credit", credit, 2'b01);
    chk("a1_pop_count0", count0, 0);
    cycle();
    chk("a1_credit_off", credit, 2'b00);

    // VC1 fill, overflow on the fifth push, then drain in order
    for (int i = 0; i < 5; i++) begin
      d = 36'hC_0000_0000 | 36'(i + 1);
      if (i < DEPTH) exp_q.push_back(d);
      set_in(1'b1, 1'b1, d, 1'b0, 1'b0);
      cycle();
    end
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("vc1_full_count1", count1, 4);
    chk("vc1_ovf", ovf, 2'b10);
    chk("vc1_no_credit", credit, 2'b00);
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("vc1_drain_order", odata1, exp_q.pop_front());
      cycle();
      chk("vc1_drain_credit", credit, 2'b10);
    end
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("vc1_empty_ovalid1", ovalid1, 0);
    chk("vc1_empty_count1", count1, 0);
    cycle();
    chk("vc1_ovf_sticky", ovf, 2'b10);

    // VC0 full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) begin
      d = 36'hD_0000_0000 | 36'(i + 1);
      if (i > 0) exp_q.push_back(d);
      set_in(1'b1, 1'b0, d, 1'b0, 1'b0);
      cycle();
    end
    chk("vc0_full_count0", count0, 4);
    exp_q.push_back(36'hD_0000_0005);
    set_in(1'b1, 1'b0, 36'hD_0000_0005, 1'b1, 1'b0);
    cycle();
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("full_pp_count0", count0, 4);
    chk("full_pp_ovf", ovf, 2'b10);
    chk("full_pp_credit", credit, 2'b01);
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("full_pp_drain_order", odata0, exp_q.pop_front());
      cycle();
    end
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("full_pp_drained", count0, 0);

    // simultaneous pops on both VCs
    set_in(1'b1, 1'b0, 36'hE_0000_0001, 1'b0, 1'b0);
    cycle();
    set_in(1'b1, 1'b0, 36'hE_0000_0002, 1'b0, 1'b0);
    cycle();
    set_in(1'b1, 1'b1, 36'hF_0000_0001, 1'b0, 1'b0);
    cycle();
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b1);
    cycle();
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("dual_count0", count0, 1);
    chk("dual_count1", count1, 0);
    chk("dual_credit", credit, 2'b11);
    cycle();
    chk("dual_credit_once", credit, 2'b00);
    chk("dual_vc0_head", odata0, 36'hE_0000_0002);
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle();
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("dual_vc0_drained", count0, 0);

    // asynchronous reset mid-operation with a pending credit
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 36'h6_0000_0000 | 36'(i + 1), 1'b0, 1'b0);
      cycle();
    end
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("pre_rst_count0", count0, 3);
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    rst_ = 1'b1;
    #1;
    chk("async_rst_count0", count0, 0);
    chk("async_rst_ovalid0", ovalid0, 0);
    chk("async_rst_credit", credit, 2'b00);
    chk("async_rst_ovf", ovf, 2'b00);
    set_in(1'b1, 1'b0, 36'h7_0000_0001, 1'b1, 1'b0);
    cycle();
    chk("rst_push_ignored", count0, 0);
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    rst_ = 1'b0;
    set_in(1'b1, 1'b0, 36'hB_0000_0001, 1'b0, 1'b0);
    cycle();
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("b1_ovalid0", ovalid0, 1);
    chk("b1_odata0", odata0, 36'hB_0000_0001);
    chk("b1_count0", count0, 1);
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle();
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("b1_credit", credit, 2'b01);

    // pointer wrap: 2*DEPTH+1 push/pop pairs on VC0
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      d = 36'h9_0000_0000 | 36'(i * 16 + 3);
      set_in(1'b1, 1'b0, d, 1'b0, 1'b0);
      cycle();
      chk("wrap_push_credit", credit, 2'b00);
      chk("wrap_data", odata0, d);
      set_in(1'b0, 1'b0, '0, 1'b1, 1'b0);
      cycle();
      chk("wrap_pop_credit", credit, 2'b01);
      chk("wrap_count0", count0, 0);
    end
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle();
    chk("wrap_credit_off", credit, 2'b00);
    chk("final_ovf", ovf, 2'b00);

    // report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
